async_fifo_rd_drain: RTL and testbench
======================================

# async_fifo_rd_drain

Read-side consumer for the asynchronous FIFO: runs in the read clock domain, issues `read_enable` toward the FIFO whenever data is available and buffer credit exists, absorbs the FIFO's one-cycle read latency in a small skid buffer, and presents words on a valid/ready stream to downstream logic. It is the counterpart of the write-side producer and sits between the FIFO read port and any rclk-domain sink. With `out_ready` held high it sustains one word per cycle.

## Interface

Parameters:
- `DW`, 9, data word width (matches FIFO `data_read`)
- `SKID_DEPTH`, 4, skid buffer entries; legal range 3..16
- `CW`, 16, width of the `words_read` counter

Ports:
- `rclk` input 1 read-domain clock; all logic on rising edge
- `rrst_n` input 1 reset; synchronous and active-low
- `drain_en` input 1 permits new FIFO reads when high
- `rempty` input 1 FIFO empty flag (rclk domain)
- `data_read` input DW FIFO read data, valid the cycle after a read
- `read_enable` output 1 FIFO pop request
- `out_data` output DW downstream word (head of skid buffer)
- `out_valid` output 1 `out_data` valid
- `out_ready` input 1 downstream accepts word
- `busy` output 1 high while any read is in flight or buffer non-empty
- `words_read` output CW count of words handed downstream; wraps

## Operation

- State: skid buffer (circular, `SKID_DEPTH` entries, read/write pointers, occupancy `occ` 0..SKID_DEPTH), `inflight` 1-bit register (= `read_enable` of previous cycle), `words_read` counter.
- `read_enable` is combinational: `drain_en && !rempty && rrst_n && (occ + inflight < SKID_DEPTH)`. It never asserts while `rempty` is high.
- Capture: when `inflight` is 1, `data_read` is written into the buffer at the write pointer at the end of that cycle; occ increments (unless a pop occurs the same cycle).
- Pop: `out_valid = (occ != 0)`; `out_data` = entry at read pointer. Transfer when `out_valid && out_ready`; read pointer advances, occ decrements, `words_read` increments modulo 2^CW.
- Simultaneous capture and pop: occ unchanged, both pointers advance.
- Pointer wrap at `SKID_DEPTH-1` back to 0 (non-power-of-two depth supported).
- `out_data` must hold stable while `out_valid && !out_ready`.
- `drain_en` deassertion: no new reads issued; the in-flight word is still captured; buffered words continue to drain downstream.
- `busy = inflight || (occ != 0)`.
- Credit rule guarantees the buffer never overflows; a capture into a full buffer is a design error (assertion in bench).

## Timing

- Reset (`rrst_n` low at a rising edge): occ=0, pointers=0, `inflight`=0, `words_read`=0; outputs: `read_enable`=0 (gated combinationally by `rrst_n`), `out_valid`=0, `out_data`=0 (buffer entries not cleared but unobservable), `busy`=0.
- Reset mid-operation: in-flight and buffered words are discarded; FIFO shares `rrst_n`, so no word is lost silently beyond the reset.
- Latency: `read_enable` high in cycle c -> `data_read` captured at end of c+1 -> `out_valid` high in cycle c+2 (2 cycles).
- Throughput: with `out_ready`=1 and `rempty`=0, `read_enable` stays high every cycle and `out_valid` stays high from cycle c+2 onward (occ settles at 1, inflight 1).
- Backpressure: with `out_ready`=0, at most `SKID_DEPTH` words are read before `read_enable` drops; it drops in the cycle where occ+inflight reaches SKID_DEPTH.
- `rempty` rising: `read_enable` falls the same cycle; no read beyond the last word.

## Test plan

- Reset: hold `rrst_n`=0 for 3 cycles with `rempty`=0, `drain_en`=1 -> `read_enable`=0, `out_valid`=0, `busy`=0, `words_read`=0 throughout.
- Single word: FIFO holds 0x1A5, `out_ready`=1 -> `read_enable` high 1 cycle, `out_valid` high exactly 2 cycles later with `out_data`=0x1A5, `words_read`=1, then `busy`=0.
- Streaming: 20 words 0x000..0x013 preloaded, `out_ready`=1 -> 20 consecutive `out_valid` cycles in order, no gaps, `words_read`=20.
- Backpressure: 10 words available, `out_ready`=0 for 8 cycles -> exactly 4 reads issued, occ=4, `out_data` stable at first word; release `out_ready` -> all 10 words out in order, none dropped/duplicated.
- Drain disable / reset mid-stream: drop `drain_en` while `inflight`=1 -> in-flight word still delivered, no further reads; separately assert `rrst_n`=0 with occ=3 -> next cycle `out_valid`=0, `words_read`=0.
- Counter wrap (CW=4 build): deliver 17 words -> `words_read`=1.

Source files
------------

// File: rtl/async_fifo_rd_drain.sv
// Read-side drain for the async FIFO: pops the FIFO under buffer credit, absorbs
// its one-cycle read latency in a circular skid buffer, and presents a valid/ready stream.
module async_fifo_rd_drain #(
   parameter int DW         = 9,
   parameter int SKID_DEPTH = 4,
   parameter int CW         = 16
) (
   input  logic          rclk,
   input  logic          rrst_n,
   input  logic          drain_en,
   input  logic          rempty,
   input  logic [DW-1:0] data_read,
   output logic          read_enable,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic [CW-1:0] words_read
);
   localparam int            PW       = $clog2(SKID_DEPTH);
   localparam int            OW       = $clog2(SKID_DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(SKID_DEPTH - 1);
   localparam logic [OW:0]   DEPTH    = (OW + 1)'(SKID_DEPTH);

   logic [DW-1:0] mem [SKID_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [OW-1:0] occ;
   logic          inflight;
   logic          pop;
   logic [OW:0]   credit_used;

   // A read is only issued if its word is guaranteed a slot when it lands.
   assign credit_used = {1'b0, occ} + {{OW{1'b0}}, inflight};
   assign read_enable = drain_en && !rempty && rrst_n && (credit_used < DEPTH);
   assign out_valid   = (occ != '0);
   assign out_data    = out_valid ? mem[rd_ptr] : '0;
   assign pop         = out_valid && out_ready;
   assign busy        = inflight || out_valid;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         occ        <= '0;
         inflight   <= 1'b0;
         words_read <= '0;
      end else begin
         inflight <= read_enable;
         if (inflight) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr     <= next_ptr(rd_ptr);
            words_read <= words_read + 1'b1;
         end
         case ({inflight, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge rclk) begin
      if (inflight) begin
         mem[wr_ptr] <= data_read;
      end
   end

endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// Bench for async_fifo_rd_drain: queue-based FIFO emulation and buffer model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_async_fifo_rd_drain;
   localparam int DW = 9;
   localparam int D  = 4;
   localparam int CW = 4;

   logic          rclk = 1'b0;
   logic          rrst_n;
   logic          drain_en;
   logic          rempty;
   logic [DW-1:0] data_read;
   logic          read_enable;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic [CW-1:0] words_read;

   async_fifo_rd_drain #(.DW(DW), .SKID_DEPTH(D), .CW(CW)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .drain_en(drain_en), .rempty(rempty),
      .data_read(data_read), .read_enable(read_enable), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
      .words_read(words_read)
   );

   always #5 rclk = ~rclk;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] mq[$];
   logic          m_inflight = 1'b0;
   logic [CW-1:0] m_words    = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: buffer is a queue of words, one word in flight, a wrapping count.
   always @(negedge rclk) begin : compare
      logic exp_re;
      logic exp_valid;
      int   sz0;
      sz0       = mq.size();
      exp_re    = rrst_n && drain_en && !rempty && (sz0 + int'(m_inflight) < D);
      exp_valid = (sz0 != 0);
      chk("read_enable", 32'(read_enable), 32'(exp_re));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) chk("out_data", 32'(out_data), 32'(mq[0]));
      chk("busy", 32'(busy), 32'(m_inflight || exp_valid));
      chk("words_read", 32'(words_read), 32'(m_words));
      if (!rrst_n) begin
         mq.delete();
         m_inflight = 1'b0;
         m_words    = '0;
      end else begin
         if (m_inflight) chk("skid_credit", 32'(sz0 < D), 32'd1);
         if (exp_valid && out_ready) begin
            void'(mq.pop_front());
            m_words = m_words + 1'b1;
         end
         if (m_inflight) mq.push_back(data_read);
         m_inflight = exp_re;
      end
   end

   // One clock: FIFO answers the read seen last cycle, then new inputs apply.
   task automatic tick(input logic rst_i, input logic drain_i, input logic ready_i);
      logic re_s;
      logic rst_s;
      re_s  = read_enable;
      rst_s = rrst_n;
      @(posedge rclk);
      #1;
      if (!rst_s) begin
         fifo_q.delete();
         data_read = DW'($urandom);
      end else if (re_s) begin
         chk("read_not_empty", 32'(fifo_q.size() != 0), 32'd1);
         data_read = (fifo_q.size() != 0) ? fifo_q.pop_front() : '0;
      end else begin
         data_read = DW'($urandom);
      end
      rrst_n    = rst_i;
      drain_en  = drain_i;
      out_ready = ready_i;
      rempty    = rst_i ? (fifo_q.size() == 0) : 1'b0;
      @(negedge rclk);
      #2;
   endtask

   initial begin
      int first, last, nv, nre, guard;
      rrst_n    = 1'b0;
      drain_en  = 1'b1;
      rempty    = 1'b0;
      out_ready = 1'b1;
      data_read = '0;

      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b1, 1'b1);
         chk("rst_read_enable", 32'(read_enable), 32'd0);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_words_read", 32'(words_read), 32'd0);
         chk("rst_out_data", 32'(out_data), 32'd0);
      end
      tick(1'b1, 1'b1, 1'b1);

      // single word
      fifo_q.push_back(9'h1A5);
      tick(1'b1, 1'b1, 1'b1);
      chk("single_re", 32'(read_enable), 32'd1);
      tick(1'b1, 1'b1, 1'b1);
      chk("single_re_off", 32'(read_enable), 32'd0);
      chk("single_valid_early", 32'(out_valid), 32'd0);
      tick(1'b1, 1'b1, 1'b1);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_data", 32'(out_data), 32'h1A5);
      tick(1'b1, 1'b1, 1'b1);
      chk("single_words", 32'(words_read), 32'd1);
      chk("single_idle", 32'(busy), 32'd0);

      // streaming
      for (int i = 0; i < 20; i++) fifo_q.push_back(DW'(i));
      first = -1; last = -1; nv = 0;
      for (int t = 0; t < 40; t++) begin
         tick(1'b1, 1'b1, 1'b1);
         if (out_valid) begin
            if (first < 0) first = t;
            last = t;
            nv++;
         end
      end
      chk("stream_count", 32'(nv), 32'd20);
      chk("stream_gapless", 32'(last - first + 1), 32'd20);
      chk("stream_words", 32'(words_read), 32'd5);

      // backpressure
      for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(9'h100 + i));
      nre = 0;
      for (int t = 0; t < 8; t++) begin
         tick(1'b1, 1'b1, 1'b0);
         if (read_enable) nre++;
      end
      chk("bp_reads", 32'(nre), 32'd4);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_head", 32'(out_data), 32'h100);
      nv = 0;
      for (int t = 0; t < 40; t++) begin
         tick(1'b1, 1'b1, 1'b1);
         if (out_valid) nv++;
      end
      chk("bp_delivered", 32'(nv), 32'd10);
      chk("bp_words", 32'(words_read), 32'd15);

      // reset with three words buffered
      for (int i = 0; i < 5; i++) fifo_q.push_back(DW'(9'h0A0 + i));
      for (int t = 0; t < 3; t++) tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      chk("mid_valid", 32'(out_valid), 32'd1);
      chk("mid_head", 32'(out_data), 32'h0A0);
      chk("mid_words", 32'(words_read), 32'd15);
      tick(1'b0, 1'b1, 1'b0);
      chk("mid_rst_re", 32'(read_enable), 32'd0);
      tick(1'b1, 1'b0, 1'b1);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_words", 32'(words_read), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);

      // counter wrap: 17 words from zero
      for (int i = 0; i < 17; i++) fifo_q.push_back(DW'($urandom));
      for (int t = 0; t < 40; t++) tick(1'b1, 1'b1, 1'b1);
      chk("wrap_words", 32'(words_read), 32'd1);
      chk("wrap_model", 32'(m_words), 32'd1);
      chk("wrap_idle", 32'(busy), 32'd0);

      // drain_en drop with one word in flight
      for (int i = 0; i < 5; i++) fifo_q.push_back(DW'(9'h0C0 + i));
      tick(1'b1, 1'b1, 1'b1);
      chk("drain_re", 32'(read_enable), 32'd1);
      tick(1'b1, 1'b0, 1'b1);
      chk("drain_re_off", 32'(read_enable), 32'd0);
      chk("drain_busy", 32'(busy), 32'd1);
      nv = 0; nre = 0;
      for (int t = 0; t < 6; t++) begin
         tick(1'b1, 1'b0, 1'b1);
         if (out_valid) nv++;
         if (read_enable) nre++;
      end
      chk("drain_delivered", 32'(nv), 32'd1);
      chk("drain_no_reads", 32'(nre), 32'd0);
      chk("drain_words", 32'(words_read), 32'd2);

      // randomized traffic
      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) fifo_q.push_back(DW'($urandom));
         end
         tick(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 2) != 0));
      end

      guard = 0;
      while ((fifo_q.size() != 0 || busy) && guard < 2000) begin
         tick(1'b1, 1'b1, 1'b1);
         guard++;
      end
      tick(1'b1, 1'b1, 1'b1);
      chk("final_fifo_empty", 32'(fifo_q.size()), 32'd0);
      chk("final_busy", 32'(busy), 32'd0);
      chk("final_valid", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
